slot_io_bank: RTL

Parametrised I/O bank for the expansion card slots. It replaces hand-instantiated per-pin tristate buffers with a generated array of NUM_SLOTS x PINS_PER_SLOT bidirectional pins. Each pin gets a registered output and output-enable, an input synchroniser, and a per-slot configurable glitch filter. A bank-wide watchdog forces every pin to high-Z if the PS-side driver stops kicking it. The block sits between the block-design wrapper's SLOT_*_OUT/IN/OUTEN nets and the top-level inout pads.

---
 rtl/slot_io_pkg.sv | 23 ++
 rtl/slot_io_pin_filter.sv | 80 ++++++++
 rtl/slot_io_bank.sv | 121 ++++++++++++
 3 files changed

// File: rtl/slot_io_pkg.sv
// Shared types and defaults for the expansion-slot I/O bank.
// Holds the watchdog state encoding, the default geometry and the pin-index helper.
// Optional edge capture is enabled with SLOT_IO_EDGE_CAPTURE_EN (see slot_io_bank).
package slot_io_pkg;

   localparam int NUM_SLOTS_DEF     = 4;
   localparam int PINS_PER_SLOT_DEF = 22;
   localparam int SYNC_STAGES_DEF   = 2;
   localparam int FILTER_W_DEF      = 4;
   localparam int WDT_W_DEF         = 16;

   typedef enum logic [1:0] {
      WDT_IDLE    = 2'd0,
      WDT_ARMED   = 2'd1,
      WDT_TRIPPED = 2'd2
   } wdt_state_t;

   // Flat bit position of (slot, pin) on the pad/out_data/in_data vectors.
   function automatic int pin_idx(input int pins_per_slot, input int slot, input int pin);
      return slot * pins_per_slot + pin;
   endfunction

endpackage

// File: rtl/slot_io_pin_filter.sv
// One pin's input path: synchroniser chain, glitch filter, optional sticky edge flag.
// Latency: a pad change sampled at edge 1 reaches in_data_o at edge SYNC_STAGES+max(L,1).
// No backpressure; the pin is sampled every cycle. SYNC_STAGES must be 2..4.
module slot_io_pin_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pad_i,
   input  logic [FILTER_W-1:0] filt_len_i,
`ifdef SLOT_IO_EDGE_CAPTURE_EN
   input  logic                edge_clear_i,
   output logic                edge_flag_o,
`endif
   output logic                in_data_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic [FILTER_W-1:0]    cnt_q, cnt_d;
   logic [FILTER_W-1:0]    thr;
   logic                   in_q, in_d;
   logic                   mismatch;
   logic                   commit;

   // Shift the raw pad through the synchroniser; the last stage is the only one used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // L=0 and L=1 both mean "commit after one mismatched cycle".
   assign thr      = (filt_len_i == '0) ? '0 : filt_len_i - FILTER_W'(1);
   assign mismatch = (sync_out != in_q);
   // >= so that lowering L while a count is in flight commits immediately.
   assign commit   = mismatch && (cnt_q >= thr);

   // Filter next state: commit, keep counting the mismatch, or restart.
   always_comb begin
      cnt_d = '0;
      in_d  = in_q;
      if (commit)        in_d  = sync_out;
      else if (mismatch) cnt_d = cnt_q + FILTER_W'(1);
   end

   // Filter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         in_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         in_q  <= in_d;
      end
   end

   assign in_data_o = in_q;

`ifdef SLOT_IO_EDGE_CAPTURE_EN
   logic flag_q, flag_d;

   // Flag rises on the same edge that updates in_data, so it is seen in the following cycle;
   // a commit outranks a coincident clear.
   always_comb begin
      flag_d = commit | (flag_q & ~edge_clear_i);
   end

   // Sticky edge flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) flag_q <= 1'b0;
      else     flag_q <= flag_d;
   end

   assign edge_flag_o = flag_q;
`endif

endmodule

// File: rtl/slot_io_bank.sv
// Slot I/O bank: registered tristate outputs, filtered inputs, bank-wide output watchdog.
// Latency: out_data/out_en to pad 1 clk; pad to in_data SYNC_STAGES+max(L,1) clks.
// No backpressure. Optional edge_flags/edge_clear ports exist only with SLOT_IO_EDGE_CAPTURE_EN.
module slot_io_bank
   import slot_io_pkg::*;
#(
   parameter int NUM_SLOTS     = NUM_SLOTS_DEF,
   parameter int PINS_PER_SLOT = PINS_PER_SLOT_DEF,
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int FILTER_W      = FILTER_W_DEF,
   parameter int WDT_W         = WDT_W_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst,
   inout  wire  [NUM_SLOTS*PINS_PER_SLOT-1:0]   pad,
   input  logic [NUM_SLOTS*PINS_PER_SLOT-1:0]   out_data,
   input  logic [NUM_SLOTS*PINS_PER_SLOT-1:0]   out_en,
   output logic [NUM_SLOTS*PINS_PER_SLOT-1:0]   in_data,
   input  logic [NUM_SLOTS*FILTER_W-1:0]        filt_len,
`ifdef SLOT_IO_EDGE_CAPTURE_EN
   output logic [NUM_SLOTS*PINS_PER_SLOT-1:0]   edge_flags,
   input  logic [NUM_SLOTS*PINS_PER_SLOT-1:0]   edge_clear,
`endif
   input  logic                                 wdt_enable,
   input  logic [WDT_W-1:0]                     wdt_timeout,
   input  logic                                 wdt_kick,
   input  logic                                 wdt_clear,
   output logic                                 wdt_tripped
);

   localparam int N = NUM_SLOTS * PINS_PER_SLOT;

   logic [N-1:0]     out_q;
   logic [N-1:0]     oe_q;
   wdt_state_t       state_q, state_d;
   logic [WDT_W-1:0] wcnt_q, wcnt_d;
   logic             tripped;

   assign tripped     = (state_q == WDT_TRIPPED);
   assign wdt_tripped = tripped;

   // Output data and enable registers; a tripped watchdog masks every enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         oe_q  <= '0;
      end else begin
         out_q <= out_data;
         oe_q  <= out_en & {N{~tripped}};
      end
   end

   // Watchdog next state; a kick on the terminal cycle keeps the FSM armed.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         WDT_IDLE: begin
            wcnt_d = '0;
            if (wdt_enable && (wdt_timeout != '0)) state_d = WDT_ARMED;
         end
         WDT_ARMED: begin
            if (!wdt_enable || (wdt_timeout == '0)) begin
               state_d = WDT_IDLE;
               wcnt_d  = '0;
            end else if (wdt_kick) begin
               wcnt_d  = '0;
            end else if (wcnt_q == wdt_timeout - WDT_W'(1)) begin
               state_d = WDT_TRIPPED;
               wcnt_d  = '0;
            end else begin
               wcnt_d  = wcnt_q + WDT_W'(1);
            end
         end
         WDT_TRIPPED: begin
            wcnt_d = '0;
            if (wdt_clear) state_d = WDT_IDLE;
         end
         default: begin
            state_d = WDT_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   // Watchdog state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WDT_IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Per-pin tristate buffer and input filter; filter length is shared within a slot.
   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      for (genvar p = 0; p < PINS_PER_SLOT; p++) begin : g_pin
         localparam int I = pin_idx(PINS_PER_SLOT, s, p);

         assign pad[I] = oe_q[I] ? out_q[I] : 1'bz;

         slot_io_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W)
         ) u_filt (
            .clk          (clk),
            .rst          (rst),
            .pad_i        (pad[I]),
            .filt_len_i   (filt_len[s*FILTER_W +: FILTER_W]),
`ifdef SLOT_IO_EDGE_CAPTURE_EN
            .edge_clear_i (edge_clear[I]),
            .edge_flag_o  (edge_flags[I]),
`endif
            .in_data_o    (in_data[I])
         );
      end
   end

endmodule
